// File: rtl/stage_sequencer.sv
// Game stage sequencer: steps through stages, pulses the per-object resets on stage entry
// and gates per-object enables with the channel set mapped to the current stage.
module stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int NUM_OBJECTS = 5,
  parameter logic [NUM_STAGES*NUM_OBJECTS-1:0] STAGE_MAP = {4{5'b11111}},
  parameter int RESET_CYCLES = 2,
  parameter int CLEAR_FRAMES = 60,
  localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   start_game,
  input  logic                   pause,
  input  logic                   skip_stage,
  input  logic                   win_stage,
  input  logic                   player_dead,
  output logic [NUM_OBJECTS-1:0] enable,
  output logic [NUM_OBJECTS-1:0] resetN_obj,
  output logic [STAGE_W-1:0]     stage_num,
  output logic                   stage_active,
  output logic                   game_won,
  output logic                   game_over
);

  typedef enum logic [2:0] {
    IDLE, STAGE_RESET, PLAY, PAUSED, STAGE_CLEAR, WON, LOST
  } state_t;

  localparam int MAP_DEPTH = 1 << STAGE_W;
  localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [9:0] CLR_LAST = 10'(CLEAR_FRAMES);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

  state_t state_reg, state_next;
  logic [STAGE_W-1:0] stage_reg, stage_next;
  logic [7:0] rst_cnt_reg, rst_cnt_next;
  logic [9:0] frame_cnt_reg, frame_cnt_next;
  logic skip_prev_reg, start_prev_reg;
  logic skip_rise, start_rise;

  logic [NUM_OBJECTS-1:0] enable_next, obj_next, map_cur;
  logic active_next, won_next, over_next;

  // Unused table rows (stage index past NUM_STAGES-1) read as all-off.
  logic [NUM_OBJECTS-1:0] map_tbl [MAP_DEPTH];
  genvar gi;
  generate
    for (gi = 0; gi < MAP_DEPTH; gi++) begin : g_map
      if (gi < NUM_STAGES) begin : g_used
        assign map_tbl[gi] = STAGE_MAP[gi*NUM_OBJECTS +: NUM_OBJECTS];
      end else begin : g_unused
        assign map_tbl[gi] = '0;
      end
    end
  endgenerate

  assign map_cur    = map_tbl[stage_reg];
  assign skip_rise  = skip_stage & ~skip_prev_reg;
  assign start_rise = start_game & ~start_prev_reg;

  always_comb begin
    state_next     = state_reg;
    stage_next     = stage_reg;
    rst_cnt_next   = '0;
    frame_cnt_next = '0;
    enable_next    = '0;
    obj_next       = resetN_obj;
    active_next    = 1'b0;
    won_next       = 1'b0;
    over_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_game) begin
          stage_next = '0;
          state_next = STAGE_RESET;
        end
      end
      STAGE_RESET: begin
        obj_next = '0;
        if (rst_cnt_reg == RST_LAST) state_next = PLAY;
        else                         rst_cnt_next = rst_cnt_reg + 8'd1;
      end
      PLAY: begin
        enable_next = map_cur;
        obj_next    = map_cur;
        active_next = 1'b1;
        if (player_dead)                  state_next = LOST;
        else if (win_stage || skip_rise)  state_next = STAGE_CLEAR;
        else if (pause)                   state_next = PAUSED;
      end
      PAUSED: begin
        if (!pause) state_next = PLAY;
      end
      STAGE_CLEAR: begin
        if (player_dead) begin
          state_next = LOST;
        end else if (frame_cnt_reg == CLR_LAST) begin
          if (stage_reg == STAGE_LAST) begin
            state_next = WON;
          end else begin
            stage_next = stage_reg + STAGE_W'(1);
            state_next = STAGE_RESET;
          end
        end else if (startOfFrame) begin
          frame_cnt_next = frame_cnt_reg + 10'd1;
        end else begin
          frame_cnt_next = frame_cnt_reg;
        end
      end
      WON, LOST: begin
        won_next  = (state_reg == WON);
        over_next = (state_reg == LOST);
        if (start_rise) begin
          stage_next = '0;
          state_next = STAGE_RESET;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail state entry by one clock.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= IDLE;
      stage_reg      <= '0;
      rst_cnt_reg    <= '0;
      frame_cnt_reg  <= '0;
      skip_prev_reg  <= 1'b0;
      start_prev_reg <= 1'b0;
      enable         <= '0;
      resetN_obj     <= '0;
      stage_num      <= '0;
      stage_active   <= 1'b0;
      game_won       <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stage_reg      <= stage_next;
      rst_cnt_reg    <= rst_cnt_next;
      frame_cnt_reg  <= frame_cnt_next;
      skip_prev_reg  <= skip_stage;
      start_prev_reg <= start_game;
      enable         <= enable_next;
      resetN_obj     <= obj_next;
      stage_num      <= stage_reg;
      stage_active   <= active_next;
      game_won       <= won_next;
      game_over      <= over_next;
    end
  end

endmodule
